// File: rtl/fetch_decode_reg.sv
// Fetch/decode pipeline register with taken-branch squash FSM and bubble insertion.
// Optional FETCH_DECODE_PERF_EN adds stall and squash event counters.
module fetch_decode_reg #(
  parameter int         SQUASH_CYCLES = 1,
  parameter logic [5:0] NOP_FUNCT     = 6'h15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        Taken,
  input  logic [5:0]  FetchOpCode,
  input  logic [5:0]  FetchFunction,
  input  logic [4:0]  FetchRs1,
  input  logic [4:0]  FetchRs2,
  input  logic [4:0]  FetchRd,
  input  logic        FetchRdFp,
  input  logic [15:0] FetchImmediate,
  input  logic [31:0] FetchPCPlusFour,
  output logic [5:0]  OpCode,
  output logic [5:0]  Function,
  output logic [4:0]  Rs1,
  output logic [4:0]  Rs2,
  output logic [4:0]  Rd,
  output logic [15:0] Immediate,
  output logic [31:0] PCPlusFour,
  output logic [5:0]  DecodeOpCode,
  output logic [5:0]  DecodeRd,
  output logic [31:0] DecodePCPlusFour,
  output logic        Valid
`ifdef FETCH_DECODE_PERF_EN
  ,
  output logic [31:0] StallCount,
  output logic [31:0] SquashCount
`endif
);

  // state  | meaning
  // RUN    | capture fetch fields on every non-stalled edge
  // SQUASH | load bubbles until squash_cnt reaches 0, then return to RUN
  typedef enum logic {RUN = 1'b0, SQUASH = 1'b1} state_t;

  localparam logic [1:0] CNT_LOAD = 2'(SQUASH_CYCLES - 1);

  state_t     state;
  logic [1:0] squash_cnt;
  logic       rd_fp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      OpCode     <= 6'h00;
      Function   <= NOP_FUNCT;
      Rs1        <= 5'd0;
      Rs2        <= 5'd0;
      Rd         <= 5'd0;
      rd_fp      <= 1'b0;
      Immediate  <= 16'h0000;
      PCPlusFour <= 32'h0;
      Valid      <= 1'b0;
      state      <= RUN;
      squash_cnt <= 2'd0;
    end else if (Taken || (!stall && state == SQUASH)) begin
      // Bubble load; PC+4 still tracks fetch so decode sees a sane link value.
      OpCode     <= 6'h00;
      Function   <= NOP_FUNCT;
      Rs1        <= 5'd0;
      Rs2        <= 5'd0;
      Rd         <= 5'd0;
      rd_fp      <= 1'b0;
      Immediate  <= 16'h0000;
      PCPlusFour <= FetchPCPlusFour;
      Valid      <= 1'b0;
      if (Taken) begin
        state      <= SQUASH;
        squash_cnt <= CNT_LOAD;
      end else if (squash_cnt == 2'd0) begin
        state      <= RUN;
      end else begin
        squash_cnt <= squash_cnt - 2'd1;
      end
    end else if (!stall) begin
      OpCode     <= FetchOpCode;
      Function   <= FetchFunction;
      Rs1        <= FetchRs1;
      Rs2        <= FetchRs2;
      Rd         <= FetchRd;
      rd_fp      <= FetchRdFp;
      Immediate  <= FetchImmediate;
      PCPlusFour <= FetchPCPlusFour;
      Valid      <= 1'b1;
    end
  end

  assign DecodeOpCode     = OpCode;
  assign DecodeRd         = {rd_fp, Rd};
  assign DecodePCPlusFour = PCPlusFour;

`ifdef FETCH_DECODE_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StallCount  <= 32'd0;
      SquashCount <= 32'd0;
    end else begin
      if (stall && !Taken)
        StallCount <= StallCount + 32'd1;
      if (Taken || (!stall && state == SQUASH))
        SquashCount <= SquashCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_decode_reg.sv
// Bench for fetch_decode_reg: directed vector table, randomized run against a
// bubble-countdown reference model, and an asynchronous reset during squash.
module tb_fetch_decode_reg;
  localparam int SQ = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, Taken;
  logic [5:0]  FetchOpCode, FetchFunction;
  logic [4:0]  FetchRs1, FetchRs2, FetchRd;
  logic        FetchRdFp;
  logic [15:0] FetchImmediate;
  logic [31:0] FetchPCPlusFour;
  logic [5:0]  OpCode, Function, DecodeOpCode, DecodeRd;
  logic [4:0]  Rs1, Rs2, Rd;
  logic [15:0] Immediate;
  logic [31:0] PCPlusFour, DecodePCPlusFour;
  logic        Valid;
`ifdef FETCH_DECODE_PERF_EN
  logic [31:0] StallCount, SquashCount;
`endif

  fetch_decode_reg #(.SQUASH_CYCLES(SQ), .NOP_FUNCT(6'h15)) dut (
    .clk(clk), .reset(reset), .stall(stall), .Taken(Taken),
    .FetchOpCode(FetchOpCode), .FetchFunction(FetchFunction),
    .FetchRs1(FetchRs1), .FetchRs2(FetchRs2), .FetchRd(FetchRd),
    .FetchRdFp(FetchRdFp), .FetchImmediate(FetchImmediate),
    .FetchPCPlusFour(FetchPCPlusFour),
    .OpCode(OpCode), .Function(Function), .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd),
    .Immediate(Immediate), .PCPlusFour(PCPlusFour),
    .DecodeOpCode(DecodeOpCode), .DecodeRd(DecodeRd),
    .DecodePCPlusFour(DecodePCPlusFour), .Valid(Valid)
`ifdef FETCH_DECODE_PERF_EN
    , .StallCount(StallCount), .SquashCount(SquashCount)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: what decode should hold, plus bubbles still owed after a taken transfer.
  logic [5:0]  m_op, m_fn;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic        m_fp, m_v;
  logic [15:0] m_imm;
  logic [31:0] m_pc;
  int          m_left;
  int unsigned m_stalls, m_squashes;

  typedef struct {
    logic        stall, taken;
    logic [5:0]  op, fn;
    logic [4:0]  rd;
    logic        fp;
    logic [31:0] pc;
    logic [5:0]  e_op, e_fn, e_rd;
    logic [31:0] e_pc;
    logic        e_v;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_op = 6'h00; m_fn = 6'h15; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_fp = 0;
    m_imm = 0; m_pc = 0; m_v = 0; m_left = 0; m_stalls = 0; m_squashes = 0;
  endtask

  task automatic model_bubble();
    m_op = 6'h00; m_fn = 6'h15; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_fp = 0;
    m_imm = 0; m_pc = FetchPCPlusFour; m_v = 0; m_squashes++;
  endtask

  task automatic model_edge();
    if (Taken) begin
      model_bubble();
      m_left = SQ;
    end else if (stall) begin
      m_stalls++;
    end else if (m_left > 0) begin
      model_bubble();
      m_left--;
    end else begin
      m_op = FetchOpCode; m_fn = FetchFunction; m_rs1 = FetchRs1; m_rs2 = FetchRs2;
      m_rd = FetchRd; m_fp = FetchRdFp; m_imm = FetchImmediate; m_pc = FetchPCPlusFour;
      m_v = 1'b1;
    end
  endtask

  task automatic step(input logic s, input logic t, input logic [5:0] op, input logic [5:0] fn,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic fp, input logic [15:0] imm, input logic [31:0] pc);
    stall = s; Taken = t; FetchOpCode = op; FetchFunction = fn; FetchRs1 = rs1;
    FetchRs2 = rs2; FetchRd = rd; FetchRdFp = fp; FetchImmediate = imm; FetchPCPlusFour = pc;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".OpCode"}, 32'(OpCode), 32'(m_op));
    chk({tag, ".Function"}, 32'(Function), 32'(m_fn));
    chk({tag, ".Rs1Rs2"}, 32'({Rs1, Rs2}), 32'({m_rs1, m_rs2}));
    chk({tag, ".Immediate"}, 32'(Immediate), 32'(m_imm));
    chk({tag, ".DecodeRd"}, 32'(DecodeRd), 32'({m_fp, m_rd}));
    chk({tag, ".DecodeOpCode"}, 32'(DecodeOpCode), 32'(m_op));
    chk({tag, ".DecodePCPlusFour"}, DecodePCPlusFour, m_pc);
    chk({tag, ".Valid"}, 32'(Valid), 32'(m_v));
`ifdef FETCH_DECODE_PERF_EN
    chk({tag, ".StallCount"}, StallCount, m_stalls);
    chk({tag, ".SquashCount"}, SquashCount, m_squashes);
`endif
  endtask

  function automatic vec_t mk(input logic s, input logic t, input logic [5:0] op,
                              input logic [5:0] fn, input logic [4:0] rd, input logic fp,
                              input logic [31:0] pc, input logic [5:0] e_op,
                              input logic [5:0] e_fn, input logic [5:0] e_rd,
                              input logic [31:0] e_pc, input logic e_v);
    vec_t v;
    v.stall = s; v.taken = t; v.op = op; v.fn = fn; v.rd = rd; v.fp = fp; v.pc = pc;
    v.e_op = e_op; v.e_fn = e_fn; v.e_rd = e_rd; v.e_pc = e_pc; v.e_v = e_v;
    return v;
  endfunction

  initial begin
    // With two squash cycles a taken edge is followed by two more bubble edges.
    tbl[0]  = mk(0, 0, 6'h08, 6'h01, 5'd3, 1, 32'h104, 6'h08, 6'h01, 6'h23, 32'h104, 1);
    tbl[1]  = mk(1, 0, 6'h0A, 6'h02, 5'd4, 0, 32'h108, 6'h08, 6'h01, 6'h23, 32'h104, 1);
    tbl[2]  = mk(1, 0, 6'h0B, 6'h03, 5'd5, 0, 32'h10C, 6'h08, 6'h01, 6'h23, 32'h104, 1);
    tbl[3]  = mk(1, 0, 6'h0C, 6'h04, 5'd6, 0, 32'h110, 6'h08, 6'h01, 6'h23, 32'h104, 1);
    tbl[4]  = mk(0, 1, 6'h0D, 6'h05, 5'd7, 1, 32'h114, 6'h00, 6'h15, 6'h00, 32'h114, 0);
    tbl[5]  = mk(0, 0, 6'h0E, 6'h06, 5'd8, 1, 32'h118, 6'h00, 6'h15, 6'h00, 32'h118, 0);
    tbl[6]  = mk(0, 0, 6'h0F, 6'h07, 5'd9, 1, 32'h11C, 6'h00, 6'h15, 6'h00, 32'h11C, 0);
    tbl[7]  = mk(0, 0, 6'h10, 6'h02, 5'd5, 0, 32'h120, 6'h10, 6'h02, 6'h05, 32'h120, 1);
    tbl[8]  = mk(1, 1, 6'h11, 6'h03, 5'd6, 1, 32'h124, 6'h00, 6'h15, 6'h00, 32'h124, 0);
    tbl[9]  = mk(1, 0, 6'h12, 6'h04, 5'd7, 1, 32'h128, 6'h00, 6'h15, 6'h00, 32'h124, 0);
    tbl[10] = mk(0, 0, 6'h13, 6'h05, 5'd8, 1, 32'h12C, 6'h00, 6'h15, 6'h00, 32'h12C, 0);
    tbl[11] = mk(0, 0, 6'h14, 6'h06, 5'd9, 1, 32'h130, 6'h00, 6'h15, 6'h00, 32'h130, 0);
    tbl[12] = mk(0, 0, 6'h15, 6'h03, 5'd7, 1, 32'h134, 6'h15, 6'h03, 6'h27, 32'h134, 1);

    reset = 1'b1; stall = 0; Taken = 0; FetchOpCode = 0; FetchFunction = 0; FetchRs1 = 0;
    FetchRs2 = 0; FetchRd = 0; FetchRdFp = 0; FetchImmediate = 0; FetchPCPlusFour = 0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("reset.OpCode", 32'(OpCode), 32'h00);
    chk("reset.Function", 32'(Function), 32'h15);
    chk("reset.PCPlusFour", PCPlusFour, 32'h0);
    chk("reset.Valid", 32'(Valid), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].stall, tbl[i].taken, tbl[i].op, tbl[i].fn, 5'd1, 5'd2, tbl[i].rd,
           tbl[i].fp, 16'h1234, tbl[i].pc);
      chk($sformatf("tbl%0d.OpCode", i), 32'(OpCode), 32'(tbl[i].e_op));
      chk($sformatf("tbl%0d.Function", i), 32'(Function), 32'(tbl[i].e_fn));
      chk($sformatf("tbl%0d.DecodeRd", i), 32'(DecodeRd), 32'(tbl[i].e_rd));
      chk($sformatf("tbl%0d.DecodePCPlusFour", i), DecodePCPlusFour, tbl[i].e_pc);
      chk($sformatf("tbl%0d.Valid", i), 32'(Valid), 32'(tbl[i].e_v));
`ifdef FETCH_DECODE_PERF_EN
      if (i == 3) chk("tbl.StallCount", StallCount, 32'd3);
`endif
    end
    check_model("tbl_end");

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2, 6'($urandom), 6'($urandom),
           5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 16'($urandom), $urandom);
      check_model($sformatf("rnd%0d", i));
    end

    // Asynchronous reset with one squash bubble still owed.
    step(0, 0, 6'h20, 6'h01, 5'd1, 5'd2, 5'd3, 0, 16'h0001, 32'h200);
    step(0, 1, 6'h21, 6'h02, 5'd1, 5'd2, 5'd3, 0, 16'h0002, 32'h204);
    check_model("pre_rst");
    step(0, 0, 6'h22, 6'h03, 5'd4, 5'd5, 5'd6, 1, 16'h0003, 32'h208);
    check_model("squash_cnt1");
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("midrst.OpCode", 32'(OpCode), 32'h00);
    chk("midrst.Function", 32'(Function), 32'h15);
    chk("midrst.PCPlusFour", PCPlusFour, 32'h0);
    chk("midrst.Valid", 32'(Valid), 32'h0);
    check_model("midrst");
    @(posedge clk); #3 reset = 1'b0;
    step(0, 0, 6'h23, 6'h04, 5'd7, 5'd8, 5'd9, 1, 16'hBEEF, 32'h300);
    chk("postrst.OpCode", 32'(OpCode), 32'h23);
    chk("postrst.DecodeRd", 32'(DecodeRd), 32'h29);
    chk("postrst.PCPlusFour", PCPlusFour, 32'h300);
    chk("postrst.Valid", 32'(Valid), 32'h1);
    check_model("postrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
